nios2_div_cell: RTL and testbench

- Iterative 32-bit integer divider for the Nios II execute path: the inverse counterpart of the pipelined multiply cell.
- Accepts dividend/divisor plus a signed/unsigned control from E-stage, computes quotient and remainder with a radix-2 restoring algorithm, one bit per cycle.
- Handshakes completion back to the pipeline stall logic with a start/busy/done protocol; shares the M_en stall enable with the multiply path.

---
 rtl/nios2_div_pkg.sv | 18 +
 rtl/nios2_div_step.sv | 31 +++
 rtl/nios2_div_cell.sv | 154 +++++++++++++++
 tb/tb_nios2_div_cell.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_div_pkg.sv
// Shared definitions for the Nios II iterative divide cell: widths, FSM state
// encodings and the divide-by-zero quotient value.
package nios2_div_pkg;

    localparam int DIV_W     = 32;
    localparam int DIV_CNT_W = $clog2(DIV_W) + 1;

    typedef logic [2:0] div_state_t;

    localparam div_state_t ST_IDLE = 3'd0;
    localparam div_state_t ST_PREP = 3'd1;
    localparam div_state_t ST_CALC = 3'd2;
    localparam div_state_t ST_FIX  = 3'd3;
    localparam div_state_t ST_DONE = 3'd4;

    localparam logic [DIV_W-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/nios2_div_step.sv
// One restoring-division iteration: shift {rem, quot} left, trial-subtract the
// divisor and keep the difference when it does not go negative.
module nios2_div_step
    import nios2_div_pkg::*;
#(
    parameter int DATA_W = DIV_W
) (
    input  logic [DATA_W-1:0] rem,
    input  logic [DATA_W-1:0] quot,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_next,
    output logic [DATA_W-1:0] quot_next
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;

    // rem < divisor on entry, so the shifted partial remainder fits in DATA_W+1 bits
    assign shifted = {rem, quot[DATA_W-1]};
    assign diff    = shifted - {1'b0, divisor};

    always_comb begin
        rem_next  = shifted[DATA_W-1:0];
        quot_next = {quot[DATA_W-2:0], 1'b0};
        if (!diff[DATA_W]) begin
            rem_next  = diff[DATA_W-1:0];
            quot_next = {quot[DATA_W-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/nios2_div_cell.sv
// Iterative signed/unsigned divider for the Nios II execute path with a
// start/busy/done handshake to the stall logic.
//
//   state | meaning
//   IDLE  | waiting for a start; done pulse (if any) is visible here
//   PREP  | take operand magnitudes, latch sign fix-ups and zero-divisor flag
//   CALC  | one restoring step per cycle, DATA_W cycles
//   FIX   | apply sign fix-up or divide-by-zero override
//   DONE  | publish results; done pulses on the following cycle
module nios2_div_cell
    import nios2_div_pkg::*;
#(
    parameter int DATA_W = DIV_W,
    parameter int CNT_W  = DIV_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              E_div_start,
    input  logic              E_ctrl_div_signed,
    input  logic [DATA_W-1:0] E_src1,
    input  logic [DATA_W-1:0] E_src2,
    input  logic              M_en,
    input  logic              M_div_abort,
    output logic              M_div_busy,
    output logic              M_div_done,
    output logic [DATA_W-1:0] M_div_quot,
    output logic [DATA_W-1:0] M_div_rem,
    output logic              M_div_by_zero
);

    div_state_t        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              signed_q;
    logic              q_neg_q;
    logic              r_neg_q;
    logic              dz_q;
    logic [DATA_W-1:0] src1_q;
    logic [DATA_W-1:0] src2_q;
    logic [DATA_W-1:0] div_q;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quot_q;
    logic [DATA_W-1:0] step_rem;
    logic [DATA_W-1:0] step_quot;
    logic              busy_q;
    logic              done_q;
    logic              dz_out_q;
    logic [DATA_W-1:0] quot_out_q;
    logic [DATA_W-1:0] rem_out_q;
    logic              src1_neg;
    logic              src2_neg;

    assign src1_neg = signed_q & src1_q[DATA_W-1];
    assign src2_neg = signed_q & src2_q[DATA_W-1];

    nios2_div_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .rem       (rem_q),
        .quot      (quot_q),
        .divisor   (div_q),
        .rem_next  (step_rem),
        .quot_next (step_quot)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            signed_q   <= 1'b0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            dz_q       <= 1'b0;
            src1_q     <= '0;
            src2_q     <= '0;
            div_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dz_out_q   <= 1'b0;
            quot_out_q <= '0;
            rem_out_q  <= '0;
        end else if (M_en) begin
            if (state_q != ST_IDLE && M_div_abort) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        done_q <= 1'b0;
                        // the done cycle sits in IDLE; a start seen there is dropped
                        if (E_div_start && !M_div_abort && !done_q) begin
                            src1_q   <= E_src1;
                            src2_q   <= E_src2;
                            signed_q <= E_ctrl_div_signed;
                            state_q  <= ST_PREP;
                        end
                    end
                    ST_PREP: begin
                        quot_q  <= src1_neg ? -src1_q : src1_q;
                        div_q   <= src2_neg ? -src2_q : src2_q;
                        rem_q   <= '0;
                        q_neg_q <= src1_neg ^ src2_neg;
                        r_neg_q <= src1_neg;
                        dz_q    <= (src2_q == '0);
                        cnt_q   <= CNT_W'(DATA_W - 1);
                        busy_q  <= 1'b1;
                        state_q <= ST_CALC;
                    end
                    ST_CALC: begin
                        rem_q  <= step_rem;
                        quot_q <= step_quot;
                        if (cnt_q == '0) begin
                            state_q <= ST_FIX;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    ST_FIX: begin
                        if (dz_q) begin
                            quot_q <= '1;
                            rem_q  <= src1_q;
                        end else begin
                            if (q_neg_q) quot_q <= -quot_q;
                            if (r_neg_q) rem_q  <= -rem_q;
                        end
                        state_q <= ST_DONE;
                    end
                    ST_DONE: begin
                        quot_out_q <= quot_q;
                        rem_out_q  <= rem_q;
                        dz_out_q   <= dz_q;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign M_div_busy    = busy_q;
    assign M_div_done    = done_q;
    assign M_div_quot    = quot_out_q;
    assign M_div_rem     = rem_out_q;
    assign M_div_by_zero = dz_out_q;

endmodule

// File: tb/tb_nios2_div_cell.sv
// Self-checking bench for nios2_div_cell: arithmetic reference model with a
// latency countdown, per-cycle output comparison and directed/random operations.
module tb_nios2_div_cell;
    import nios2_div_pkg::*;

    localparam int LAT = 35;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sgn;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        M_en;
    logic        abort;
    logic        M_div_busy;
    logic        M_div_done;
    logic [31:0] M_div_quot;
    logic [31:0] M_div_rem;
    logic        M_div_by_zero;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // reference model state
    bit          m_active = 1'b0;
    int          m_left   = 0;
    bit          m_busy   = 1'b0;
    bit          m_done   = 1'b0;
    logic [31:0] m_q = '0, m_r = '0;
    bit          m_dz = 1'b0;
    logic [31:0] p_q = '0, p_r = '0;
    bit          p_dz = 1'b0;

    always #5 clk = ~clk;

    nios2_div_cell dut (
        .clk               (clk),
        .reset             (reset),
        .E_div_start       (start),
        .E_ctrl_div_signed (sgn),
        .E_src1            (src1),
        .E_src2            (src2),
        .M_en              (M_en),
        .M_div_abort       (abort),
        .M_div_busy        (M_div_busy),
        .M_div_done        (M_div_done),
        .M_div_quot        (M_div_quot),
        .M_div_rem         (M_div_rem),
        .M_div_by_zero     (M_div_by_zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input bit s,
                                    output logic [31:0] q, output logic [31:0] r, output bit dz);
        int sa, sb;
        dz = 1'b0;
        if (b == 0) begin
            q  = DIV0_QUOT;
            r  = a;
            dz = 1'b1;
        end else if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 0;
            end else begin
                sa = a;
                sb = b;
                q  = sa / sb;
                r  = sa % sb;
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_active = 0; m_left = 0; m_busy = 0; m_done = 0;
            m_q = '0; m_r = '0; m_dz = 0;
        end else if (M_en) begin
            if (m_active) begin
                if (abort) begin
                    m_active = 0; m_busy = 0; m_done = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_active = 0; m_busy = 0; m_done = 1;
                        m_q = p_q; m_r = p_r; m_dz = p_dz;
                    end else begin
                        m_busy = 1;
                    end
                end
            end else begin
                if (start && !abort && !m_done) begin
                    ref_div(src1, src2, sgn, p_q, p_r, p_dz);
                    m_active = 1;
                    m_left   = LAT;
                end
                m_done = 0;
                m_busy = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'd0, M_div_busy}, {31'd0, m_busy});
            check("done", {31'd0, M_div_done}, {31'd0, m_done});
            check("quot", M_div_quot, m_q);
            check("rem", M_div_rem, m_r);
            check("by_zero", {31'd0, M_div_by_zero}, {31'd0, m_dz});
        end
    end

    // Returns the negedge index (relative to the acceptance edge) at which done
    // was first seen, or -1 if it never came within the budget.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit s,
                          input int stall_at, input int stall_len,
                          input int kill_at, input bit kill_reset, input int extra_start_at,
                          output int lat, output int busy_cnt);
        @(negedge clk);
        src1 = a; src2 = b; sgn = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        busy_cnt = M_div_busy ? 1 : 0;
        for (int j = 1; j <= 120; j++) begin
            @(negedge clk);
            if (M_div_busy) busy_cnt++;
            if (M_div_done) begin
                lat = j;
                break;
            end
            reset = (kill_at > 0 && j == kill_at && kill_reset);
            abort = (kill_at > 0 && j == kill_at && !kill_reset);
            M_en  = !(stall_len > 0 && j >= stall_at && j < stall_at + stall_len);
            start = (j == extra_start_at);
            if (kill_at > 0 && j > kill_at + 40) break;
        end
        start = 1'b0; abort = 1'b0; reset = 1'b0; M_en = 1'b1;
    endtask

    initial begin
        int lat, bc;
        logic [31:0] q, r, a, b;
        bit dz, s;
        int st_at, st_len;

        reset = 1'b1; start = 1'b0; sgn = 1'b0; src1 = '0; src2 = '0;
        M_en = 1'b1; abort = 1'b0;

        // pin the model against hand-computed values
        ref_div(32'd100, 32'd7, 1'b0, q, r, dz);
        check("model_100_7_q", q, 32'd14);
        check("model_100_7_r", r, 32'd2);
        ref_div(32'hFFFF_FFF9, 32'd2, 1'b1, q, r, dz);
        check("model_m7_2_q", q, 32'hFFFF_FFFD);
        check("model_m7_2_r", r, 32'hFFFF_FFFF);
        ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, q, r, dz);
        check("model_u_edge_r", r, 32'h8000_0000);

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", {31'd0, M_div_busy}, 32'd0);
        check("rst_done", {31'd0, M_div_done}, 32'd0);
        check("rst_quot", M_div_quot, 32'd0);
        check("rst_rem", M_div_rem, 32'd0);
        chk_en = 1'b1;

        // 1: unsigned 100/7
        run_op(32'd100, 32'd7, 1'b0, 0, 0, 0, 1'b0, 0, lat, bc);
        check("lat_100_7", lat, LAT);
        check("busy_cycles_100_7", bc, 34);
        check("q_100_7", M_div_quot, 32'd14);
        check("r_100_7", M_div_rem, 32'd2);

        // 2: signed cases
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 0, 0, 1'b0, 0, lat, bc);
        check("q_m7_2", M_div_quot, 32'hFFFF_FFFD);
        check("r_m7_2", M_div_rem, 32'hFFFF_FFFF);
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0, 0, 0, 1'b0, 0, lat, bc);
        check("q_7_m2", M_div_quot, 32'hFFFF_FFFD);
        check("r_7_m2", M_div_rem, 32'd1);

        // 3: divide by zero, then a valid divide clears the flag
        run_op(32'h1234_5678, 32'd0, 1'b0, 0, 0, 0, 1'b0, 0, lat, bc);
        check("lat_div0", lat, LAT);
        check("q_div0", M_div_quot, 32'hFFFF_FFFF);
        check("r_div0", M_div_rem, 32'h1234_5678);
        check("dz_div0", {31'd0, M_div_by_zero}, 32'd1);
        run_op(32'd9, 32'd3, 1'b0, 0, 0, 0, 1'b0, 0, lat, bc);
        check("dz_cleared", {31'd0, M_div_by_zero}, 32'd0);

        // 4: edge operands
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0, 0, 1'b0, 0, lat, bc);
        check("q_s_min_m1", M_div_quot, 32'h8000_0000);
        check("r_s_min_m1", M_div_rem, 32'd0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 0, 0, 1'b0, 0, lat, bc);
        check("q_u_edge", M_div_quot, 32'd0);
        check("r_u_edge", M_div_rem, 32'h8000_0000);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0, 0, 0, 1'b0, 0, lat, bc);
        check("q_u_max_1", M_div_quot, 32'hFFFF_FFFF);

        // 5: stall mid-CALC, ignored second start, done held under stall
        run_op(32'd1000, 32'd3, 1'b0, 12, 10, 0, 1'b0, 8, lat, bc);
        check("lat_stall", lat, LAT + 10);
        check("q_1000_3", M_div_quot, 32'd333);
        check("r_1000_3", M_div_rem, 32'd1);
        M_en = 1'b0;
        start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("done_held", {31'd0, M_div_done}, 32'd1);
        end
        M_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_dropped", {31'd0, M_div_done}, 32'd0);
        bc = 0;
        repeat (40) begin
            @(negedge clk);
            if (M_div_done || M_div_busy) bc++;
        end
        check("no_extra_op", bc, 0);

        // 6: abort mid-CALC keeps previous results
        run_op(32'd50, 32'd5, 1'b0, 0, 0, 5, 1'b0, 0, lat, bc);
        check("lat_abort", lat, -1);
        check("q_after_abort", M_div_quot, 32'd333);
        check("r_after_abort", M_div_rem, 32'd1);

        // abort together with start in IDLE
        @(negedge clk);
        src1 = 32'd77; src2 = 32'd7; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_start_busy", {31'd0, M_div_busy}, 32'd0);
        repeat (40) @(negedge clk);
        check("abort_start_quot", M_div_quot, 32'd333);

        // reset mid-CALC
        run_op(32'd500, 32'd9, 1'b1, 0, 0, 10, 1'b1, 0, lat, bc);
        check("lat_reset", lat, -1);
        check("q_after_reset", M_div_quot, 32'd0);
        check("r_after_reset", M_div_rem, 32'd0);

        // randomized operations with occasional stalls
        for (int n = 0; n < 30; n++) begin
            s = $urandom_range(0, 1);
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2:    b = $urandom_range(1, 15);
                3:       b = -$urandom_range(1, 15);
                default: b = $urandom;
            endcase
            st_at = 0; st_len = 0;
            if ($urandom_range(0, 2) == 0) begin
                st_at  = $urandom_range(2, 30);
                st_len = $urandom_range(1, 5);
            end
            run_op(a, b, s, st_at, st_len, 0, 1'b0, 0, lat, bc);
            check("lat_rand", lat, LAT + st_len);
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
